// File: rtl/bitwise_logic_unit_seq.sv
// Multi-cycle bitwise logic unit: processes CHUNK bits per cycle LSB-first,
// with valid/ready handshakes on input and output and a result held until accepted.
module bitwise_logic_unit_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             parity
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_OR    = 3'b001;
  localparam logic [2:0] OP_XOR   = 3'b010;
  localparam logic [2:0] OP_NOR   = 3'b011;
  localparam logic [2:0] OP_NAND  = 3'b100;
  localparam logic [2:0] OP_XNOR  = 3'b101;
  localparam logic [2:0] OP_BCAST = 3'b110;
  localparam logic [2:0] OP_ANY   = 3'b111;

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $fatal(1, "bitwise_logic_unit_seq: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             sticky_q, sticky_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;

  logic [CHUNK-1:0] a_slc;
  logic [CHUNK-1:0] b_slc;
  logic [CHUNK-1:0] f_slc;

  // Per-slice operation; the broadcast bit always comes from the full operand's LSB.
  function automatic logic [CHUNK-1:0] slice_op(input logic [2:0]       o,
                                                input logic [CHUNK-1:0] x,
                                                input logic [CHUNK-1:0] y,
                                                input logic             bc);
    logic [CHUNK-1:0] r;
    r = '0;
    unique case (o)
      OP_AND:   r = x & y;
      OP_OR:    r = x | y;
      OP_XOR:   r = x ^ y;
      OP_NOR:   r = ~(x | y);
      OP_NAND:  r = ~(x & y);
      OP_XNOR:  r = ~(x ^ y);
      OP_BCAST: r = x | {CHUNK{bc}};
      default:  r = '0;
    endcase
    return r;
  endfunction

  // Select the operand slices addressed by the chunk counter.
  always_comb begin
    a_slc = '0;
    b_slc = '0;
    for (int unsigned k = 0; k < NCHUNK; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        a_slc = a_q[k*CHUNK +: CHUNK];
        b_slc = b_q[k*CHUNK +: CHUNK];
      end
    end
  end

  assign f_slc = slice_op(op_q, a_slc, b_slc, b_q[0]);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    sticky_d = sticky_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          op_d     = op;
          res_d    = '0;
          cnt_d    = '0;
          sticky_d = 1'b0;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        if (op_q == OP_ANY) begin
          sticky_d = sticky_q | (|(a_slc | b_slc));
        end else begin
          for (int unsigned k = 0; k < NCHUNK; k++) begin
            if (cnt_q == CNT_W'(k)) begin
              res_d[k*CHUNK +: CHUNK] = f_slc;
            end
          end
        end
        if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
          // Reduce-any result only materialises on the final slice.
          if (op_q == OP_ANY) begin
            res_d = WIDTH'(sticky_d);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      res_q    <= '0;
      sticky_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      sticky_q <= sticky_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign res       = res_q;
  assign zero      = ~|res_q;
  assign parity    = ^res_q;

endmodule
